// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, FSM states and pointer helper for rr_grant_arbiter_4
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int IDX_W = 2;
   typedef enum logic {IDLE, GRANT} state_t;
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      return IDX_W'((int'(idx) + 1) % N_REQ);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode of a 4-bit request vector
// Ports:
//   req  in  4  request vector
//   ptr  in  2  requester checked first
//   any  out 1  at least one request set
//   idx  out 2  first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);
   assign any = |req;
   // farthest offset first, so the request nearest ptr overwrites last and wins
   always_comb begin
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[ptr + IDX_W'(k)]) idx = ptr + IDX_W'(k);
      end
   end
endmodule

// File: rtl/rr_grant_arbiter_4.sv
// rr_grant_arbiter_4: four-requester round-robin arbiter with valid/ready grant handshake
// Optional feature macro: ARB_LOCK_EN (adds lock input, handshake with lock=1 keeps ptr)
// Parameters: RESET_PTR (ptr after reset), BACK2BACK (1: re-grant in handshake cycle)
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   req        in  4  request vector, bit i = requester i
//   lock       in  1  (ARB_LOCK_EN only) hold priority on this handshake
//   gnt_ready  in  1  consumer accepts the grant
//   gnt_valid  out 1  gnt_idx holds a valid grant
//   gnt_idx    out 2  index of the granted requester
module rr_grant_arbiter_4
   import arb_pkg::*;
#(
   parameter int RESET_PTR = 0,
   parameter int BACK2BACK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   input  logic             gnt_ready,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
   logic             hs, lk, lock_q, lock_d, hold, go, any;
   assign hs = (state_q == GRANT) & gnt_ready;
`ifdef ARB_LOCK_EN
   assign lk = hs & lock;
`else
   assign lk = 1'b0;
`endif
   // lock_q carries a locked handshake across the forced idle cycle when BACK2BACK=0
   assign lock_d = lk & (BACK2BACK == 0);
   assign hold = (lk | lock_q) & req[idx_q];
   assign ptr_d = hs & ~lk ? wrap_inc(idx_q) : ptr_q;
   // arbitration happens from IDLE, or in the handshake cycle when back-to-back is allowed
   assign go = (state_q == IDLE) | (hs & (BACK2BACK != 0));
   assign state_d = ((state_q == GRANT) & ~gnt_ready) | (go & (hold | any)) ? GRANT : IDLE;
   assign idx_d = go & ~hold & any ? pick_idx : idx_q;
   rr_pick u_pick (
      .req (req),
      .ptr (ptr_d),
      .any (any),
      .idx (pick_idx)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDX_W'(RESET_PTR);
         idx_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         lock_q  <= lock_d;
      end
   end
   assign gnt_valid = state_q == GRANT;
   assign gnt_idx   = idx_q;
endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// tb_rr_grant_arbiter_4: directed and random checks of two arbiter configurations against a reference model
module tb_rr_grant_arbiter_4;
   logic       clk = 1'b0, rst_n = 1'b1, gnt_ready = 1'b0, lock = 1'b0;
   logic [3:0] req = '0;
   logic [1:0] gv;
   logic [1:0] gi0, gi1;
   int         n_assert = 0, n_fail = 0;
   int         m_v[2], m_i[2], m_p[2], m_pend[2];
   localparam bit LOCK_ON =
`ifdef ARB_LOCK_EN
      1'b1;
`else
      1'b0;
`endif

   always #5 clk = ~clk;

   rr_grant_arbiter_4 #(.RESET_PTR(0), .BACK2BACK(1)) u_b2b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt_ready (gnt_ready),
      .gnt_valid (gv[0]),
      .gnt_idx   (gi0)
   );

   rr_grant_arbiter_4 #(.RESET_PTR(3), .BACK2BACK(0)) u_gap (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt_ready (gnt_ready),
      .gnt_valid (gv[1]),
      .gnt_idx   (gi1)
   );

   function automatic int first_req(logic [3:0] r, int p);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_v[d] = 0;
         m_i[d] = 0;
         m_p[d] = (d == 0) ? 0 : 3;
         m_pend[d] = 0;
      end
   endtask

   // model 0 is back-to-back, model 1 idles one cycle after every handshake
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit hs, lk;
         hs = (m_v[d] != 0) && gnt_ready;
         lk = hs && LOCK_ON && lock;
         if (m_v[d] != 0 && !gnt_ready) continue;
         if (hs && !lk) m_p[d] = (m_i[d] + 1) % 4;
         if (hs && d == 1) begin
            m_v[d] = 0;
            m_pend[d] = lk ? 1 : 0;
         end else begin
            if ((lk || m_pend[d] != 0) && req[m_i[d]]) m_v[d] = 1;
            else if (req != 0) begin
               m_v[d] = 1;
               m_i[d] = first_req(req, m_p[d]);
            end else m_v[d] = 0;
            m_pend[d] = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_models(string tag);
      chk({tag, " b2b valid"}, gv[0], m_v[0]);
      if (m_v[0] != 0) chk({tag, " b2b idx"}, gi0, m_i[0]);
      chk({tag, " gap valid"}, gv[1], m_v[1]);
      if (m_v[1] != 0) chk({tag, " gap idx"}, gi1, m_i[1]);
   endtask

   task automatic cycle(string tag);
      @(posedge clk);
      model_step();
      #1 check_models(tag);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("reset valid", gv, 2'b00);
      chk("reset idx b2b", gi0, 0);
      chk("reset idx gap", gi1, 0);
      @(negedge clk) rst_n = 1'b1;
      req = 4'b0000;
      repeat (5) begin
         cycle("idle");
         chk("idle idx b2b", gi0, 0);
         chk("idle idx gap", gi1, 0);
      end
      req = 4'b1111;
      gnt_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle("rotate");
         chk("rotate valid", gv[0], 1);
         chk("rotate idx", gi0, i % 4);
      end
      req = 4'b0000;
      cycle("drain");
      req = 4'b0100;
      gnt_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) req = 4'b0000;
         cycle("hold");
         chk("hold valid", gv[0], 1);
         chk("hold idx", gi0, 2);
      end
      gnt_ready = 1'b1;
      cycle("release");
      chk("release valid", gv[0], 0);
      req = 4'b0101;
      cycle("wrap");
      chk("wrap idx first", gi0, 0);
      cycle("wrap");
      chk("wrap idx second", gi0, 2);
      req = 4'b0000;
      cycle("drain");
      req = 4'b1111;
      gnt_ready = 1'b0;
      cycle("pre-reset");
      chk("pre-reset valid", gv, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset valid", gv, 2'b00);
      chk("async reset idx b2b", gi0, 0);
      chk("async reset idx gap", gi1, 0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      gnt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle("gap pattern");
         chk("gap pattern valid", gv[1], (i % 2) == 0);
         if (i % 2 == 0) chk("gap pattern idx", gi1, (3 + i / 2) % 4);
      end
      repeat (400) begin
         req = 4'($urandom_range(0, 15));
         gnt_ready = $urandom_range(0, 3) != 0;
         lock = 1'($urandom_range(0, 1));
         cycle("random");
      end
`ifdef ARB_LOCK_EN
      rst_n = 1'b0;
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      req = 4'b0011;
      gnt_ready = 1'b1;
      lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) lock = 1'b0;
         cycle("lock");
         chk("lock idx", gi0, (i == 3) ? 1 : 0);
      end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
